// File: rtl/id_ex_skid_stage.sv
// ---------------------------------------------------------------------------
// id_ex_skid_stage
// ID/EX pipeline boundary. Holds up to two decoded instructions (main + skid)
// behind valid/ready handshakes on both sides, so the upstream ready never
// depends combinationally on the downstream ready. Operands that the
// writeback in flight this cycle makes stale are patched with the writeback
// data, both when they are captured and while they sit in the buffer.
// ---------------------------------------------------------------------------
module id_ex_skid_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [RA_W-1:0]   in_rs1,
    input  logic [RA_W-1:0]   in_rs2,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,

    input  logic              wb_we,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]   wb_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [RA_W-1:0]   out_rs1,
    output logic [RA_W-1:0]   out_rs2,
    output logic [RA_W-1:0]   out_rd,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [XLEN-1:0]   out_imm,
    output logic [CTRL_W-1:0] out_ctrl
);

    // One buffered instruction; fields are copied bit-exact.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // State encoding is {main_v, skid_v}; the skid is only ever occupied
    // behind a valid main entry, so 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    state_e state_q;
    state_e state_d;
    entry_t main_q;
    entry_t main_d;
    entry_t skid_q;
    entry_t skid_d;
    logic   in_ready_q;
    logic   in_ready_d;

    logic   in_fire_s;
    logic   out_fire_s;
    entry_t in_raw_s;
    entry_t in_byp_s;
    entry_t main_byp_s;
    entry_t skid_byp_s;

    // A writeback to a non-zero register that matches the source index
    // supersedes whatever the register file supplied for that operand.
    function automatic logic wb_hit(
        input logic            we,
        input logic [RA_W-1:0] wrd,
        input logic [RA_W-1:0] rs
    );
        return we && (wrd != {RA_W{1'b0}}) && (wrd == rs);
    endfunction

    // Replace each operand of an entry that the current writeback targets.
    function automatic entry_t apply_wb(
        input entry_t          e,
        input logic            we,
        input logic [RA_W-1:0] wrd,
        input logic [XLEN-1:0] wdata
    );
        entry_t r;
        r = e;
        if (wb_hit(we, wrd, e.rs1)) begin
            r.rs1_data = wdata;
        end else begin
            r.rs1_data = e.rs1_data;
        end
        if (wb_hit(we, wrd, e.rs2)) begin
            r.rs2_data = wdata;
        end else begin
            r.rs2_data = e.rs2_data;
        end
        return r;
    endfunction

    assign in_fire_s  = in_valid & in_ready_q;
    assign out_fire_s = (state_q != ST_EMPTY) & out_ready;

    assign in_raw_s = '{
        pc:       in_pc,
        rs1:      in_rs1,
        rs2:      in_rs2,
        rd:       in_rd,
        rs1_data: in_rs1_data,
        rs2_data: in_rs2_data,
        imm:      in_imm,
        ctrl:     in_ctrl
    };

    assign in_byp_s   = apply_wb(in_raw_s, wb_we, wb_rd, wb_data);
    assign main_byp_s = apply_wb(main_q,   wb_we, wb_rd, wb_data);
    assign skid_byp_s = apply_wb(skid_q,   wb_we, wb_rd, wb_data);

    // Next state, buffer contents and upstream ready; flush overrides all.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_d  = in_byp_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_d  = in_byp_s;
                        state_d = ST_ONE;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else if (in_fire_s) begin
                        main_d  = main_byp_s;
                        skid_d  = in_byp_s;
                        state_d = ST_FULL;
                    end else begin
                        main_d  = main_byp_s;
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no new entry can arrive.
                    if (out_fire_s) begin
                        main_d  = skid_byp_s;
                        state_d = ST_ONE;
                    end else begin
                        main_d  = main_byp_s;
                        skid_d  = skid_byp_s;
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    // State, buffer and ready registers; reset empties the stage and zeroes data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= entry_t'({ENTRY_W{1'b0}});
            skid_q     <= entry_t'({ENTRY_W{1'b0}});
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (state_q != ST_EMPTY);
    assign out_pc       = main_q.pc;
    assign out_rs1      = main_q.rs1;
    assign out_rs2      = main_q.rs2;
    assign out_rd       = main_q.rd;
    assign out_rs1_data = main_q.rs1_data;
    assign out_rs2_data = main_q.rs2_data;
    assign out_imm      = main_q.imm;
    assign out_ctrl     = main_q.ctrl;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// ---------------------------------------------------------------------------
// Bench for id_ex_skid_stage: directed scenarios followed by random traffic,
// all compared against a queue-based model of the two-entry buffer.
// ---------------------------------------------------------------------------
module tb_id_ex_skid_stage;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic [11:0] in_ctrl;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [31:0] out_imm;
    logic [11:0] out_ctrl;

    id_ex_skid_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_imm       (in_imm),
        .in_ctrl      (in_ctrl),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_imm      (out_imm),
        .out_ctrl     (out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [11:0] ctrl;
    } ent_t;

    ent_t mq[$];          // model contents, head = what execute should see
    logic exp_ready;
    int   nvec;
    int   nerr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic hit(input logic [4:0] rs);
        return wb_we && (wb_rd != 5'd0) && (wb_rd == rs);
    endfunction

    // Advance the model by one clock edge using the inputs presented before it.
    task automatic model_edge();
        logic fire_in;
        logic fire_out;
        ent_t e;
        if (!reset_n) begin
            mq.delete();
            exp_ready = 1'b0;
        end else begin
            fire_in  = in_valid && exp_ready;
            fire_out = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                foreach (mq[i]) begin
                    if (hit(mq[i].rs1)) mq[i].d1 = wb_data;
                    if (hit(mq[i].rs2)) mq[i].d2 = wb_data;
                end
                if (fire_out) void'(mq.pop_front());
                if (fire_in) begin
                    e.pc   = in_pc;
                    e.rs1  = in_rs1;
                    e.rs2  = in_rs2;
                    e.rd   = in_rd;
                    e.d1   = hit(in_rs1) ? wb_data : in_rs1_data;
                    e.d2   = hit(in_rs2) ? wb_data : in_rs2_data;
                    e.imm  = in_imm;
                    e.ctrl = in_ctrl;
                    mq.push_back(e);
                end
            end
            exp_ready = (mq.size() < 2);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        if (mq.size() > 0) begin
            chk("out_pc", {32'd0, out_pc}, {32'd0, mq[0].pc});
            chk("out_rs1", {59'd0, out_rs1}, {59'd0, mq[0].rs1});
            chk("out_rs2", {59'd0, out_rs2}, {59'd0, mq[0].rs2});
            chk("out_rd", {59'd0, out_rd}, {59'd0, mq[0].rd});
            chk("out_rs1_data", {32'd0, out_rs1_data}, {32'd0, mq[0].d1});
            chk("out_rs2_data", {32'd0, out_rs2_data}, {32'd0, mq[0].d2});
            chk("out_imm", {32'd0, out_imm}, {32'd0, mq[0].imm});
            chk("out_ctrl", {52'd0, out_ctrl}, {52'd0, mq[0].ctrl});
        end
    endtask

    // One clock: edge, model update, then sample 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic offer(input logic v, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2);
        in_valid    = v;
        in_pc       = pc;
        in_rs1      = rs1;
        in_rs1_data = d1;
        in_rs2      = rs2;
        in_rs2_data = d2;
        in_rd       = pc[6:2];
        in_imm      = pc ^ 32'hFFFF_0000;
        in_ctrl     = pc[13:2];
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_data"},
            {out_pc ^ out_rs1_data ^ out_rs2_data ^ out_imm, 8'd0, out_rs1, out_rs2, out_rd, out_ctrl},
            64'd0);
        chk({tag, "_data_or"},
            {32'd0, out_pc | out_rs1_data | out_rs2_data | out_imm}, 64'd0);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        exp_ready = 1'b0;
        reset_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        wb_we = 1'b0;
        wb_rd = 5'd0;
        wb_data = 32'd0;
        offer(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);

        // Reset state
        cycle();
        cycle();
        check_zero_outputs("reset");
        reset_n = 1'b1;

        // 1. first entry, then 8 back-to-back entries at full rate
        out_ready = 1'b1;
        offer(1'b1, 32'h100, 5'd1, 32'h1, 5'd2, 32'h2);
        cycle();                       // in_ready rises on this edge
        chk("t1_ready_after_release", {63'd0, in_ready}, 64'd1);
        cycle();                       // 0x100 accepted
        chk("t1_first_pc", {32'd0, out_pc}, 64'h100);
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 32'h200 + 32'(4 * i), 5'd3, 32'(i), 5'd4, 32'(i + 16));
            cycle();
            chk("t1_stream_pc", {32'd0, out_pc}, 64'h200 + 64'(4 * i));
            chk("t1_stream_valid", {63'd0, out_valid}, 64'd1);
        end
        offer(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        cycle();

        // 2. stall with three offers; third is held by decode
        out_ready = 1'b0;
        offer(1'b1, 32'h10, 5'd1, 32'hA, 5'd2, 32'hB);
        cycle();
        offer(1'b1, 32'h14, 5'd1, 32'hC, 5'd2, 32'hD);
        cycle();
        chk("t2_full_ready", {63'd0, in_ready}, 64'd0);
        offer(1'b1, 32'h18, 5'd1, 32'hE, 5'd2, 32'hF);
        cycle();
        chk("t2_hold_pc", {32'd0, out_pc}, 64'h10);
        out_ready = 1'b1;
        cycle();
        chk("t2_order_2", {32'd0, out_pc}, 64'h14);
        cycle();
        chk("t2_order_3", {32'd0, out_pc}, 64'h18);
        offer(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        cycle();

        // 3. capture bypass, then no-substitution cases
        offer(1'b1, 32'h20, 5'd5, 32'h1111, 5'd6, 32'h2222);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hABCD;
        cycle();
        chk("t3_capture_hit", {32'd0, out_rs1_data}, 64'hABCD);
        offer(1'b1, 32'h24, 5'd0, 32'h1111, 5'd6, 32'h2222);
        wb_rd = 5'd0;
        cycle();
        chk("t3_no_bypass_x0", {32'd0, out_rs1_data}, 64'h1111);
        wb_we = 1'b0;
        offer(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        cycle();

        // 4. hold bypass on an entry stalled in the skid
        out_ready = 1'b0;
        offer(1'b1, 32'h40, 5'd8, 32'h8888, 5'd9, 32'h9999);
        cycle();
        offer(1'b1, 32'h44, 5'd8, 32'h8888, 5'd7, 32'h7777);
        cycle();
        offer(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
        cycle();
        wb_we = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("t4_hold_pc", {32'd0, out_pc}, 64'h44);
        chk("t4_hold_rs2", {32'd0, out_rs2_data}, 64'h55);
        cycle();

        // 5. flush while full with a new offer
        out_ready = 1'b0;
        offer(1'b1, 32'h60, 5'd1, 32'h1, 5'd2, 32'h2);
        cycle();
        offer(1'b1, 32'h64, 5'd1, 32'h1, 5'd2, 32'h2);
        cycle();
        offer(1'b1, 32'h68, 5'd1, 32'h1, 5'd2, 32'h2);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        offer(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("t5_flush_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_flush_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        cycle();
        chk("t5_never_appears", {63'd0, out_valid}, 64'd0);

        // 6. asynchronous reset while full
        out_ready = 1'b0;
        offer(1'b1, 32'h80, 5'd1, 32'h1, 5'd2, 32'h2);
        cycle();
        offer(1'b1, 32'h84, 5'd1, 32'h1, 5'd2, 32'h2);
        cycle();
        offer(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        #3;
        reset_n = 1'b0;
        #1;
        mq.delete();
        exp_ready = 1'b0;
        check_zero_outputs("t6_async");
        cycle();
        reset_n = 1'b1;
        cycle();
        out_ready = 1'b1;
        offer(1'b1, 32'h90, 5'd3, 32'h33, 5'd4, 32'h44);
        cycle();
        chk("t6_resume_pc", {32'd0, out_pc}, 64'h90);
        offer(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        cycle();

        // Random traffic with small register indices to provoke bypass hits
        for (int n = 0; n < 400; n++) begin
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = $urandom_range(0, 1);
            wb_we     = $urandom_range(0, 1);
            wb_rd     = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            offer($urandom_range(0, 3) != 0, $urandom,
                  5'($urandom_range(0, 3)), $urandom,
                  5'($urandom_range(0, 3)), $urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
